leaderboard_sorted: RTL and testbench
=====================================

LEADERBOARD_SORTED -- requirements
Module: leaderboard_sorted

Interface
REQ-001 SHALL have parameter DEPTH, default 3: number of table entries, minimum 2.
REQ-002 SHALL have parameter SCORE_W, default 8: score width, unsigned.
REQ-003 SHALL have parameter ID_W, default 3: user id width.
REQ-004 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port clr  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1: a submission is offered.
REQ-007 SHALL have port in_ready  output  1: the block accepts a submission this cycle.
REQ-008 SHALL have port in_score  input  SCORE_W: the submitted score.
REQ-009 SHALL have port in_id  input  ID_W: the submitting user id.
REQ-010 SHALL have port score_flat  output  DEPTH*SCORE_W: entry k at bits [k*SCORE_W +: SCORE_W]; entry 0 is the highest score.
REQ-011 SHALL have port id_flat  output  DEPTH*ID_W: user ids, packed the same way as score_flat.
REQ-012 SHALL have port entry_valid  output  DEPTH: bit k set means entry k is occupied.
REQ-013 SHALL have port done  output  1: one-cycle pulse when a submission finishes.
REQ-014 SHALL have port placed  output  1: qualified by done; set means the submission entered the table.
REQ-015 SHALL have port rank  output  max(1,clog2(DEPTH)): qualified by done and placed; final index of the entry.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, CMP, INS; in_ready = (state==IDLE).
REQ-017 SHALL accept on an edge with in_valid & in_ready, registering in_score/in_id, IDLE->CMP.
REQ-018 SHALL ignore in_valid and input changes while not in IDLE.
REQ-019 SHALL in CMP compute insert position p = lowest k with !entry_valid[k] or in_score >= score[k] (new entry wins ties); register p, CMP->INS.
REQ-020 SHALL set p = none when no such k exists.
REQ-021 SHALL in INS, for p != none, move entries k>=p to k+1 and write the new entry at p; entry DEPTH-1 drops off; entry_valid shifts the same way.
REQ-022 SHALL in INS, for p = none, leave the table unchanged; INS->IDLE.
REQ-023 SHALL show table updates at the edge ending INS (accept edge + 2).
REQ-024 SHALL assert done, placed and rank in the cycle after INS, together with in_ready=1; throughput is one submission per 3 cycles.
REQ-025 SHALL hold placed and rank until the next done; SHALL leave table entries at indices < p unchanged.

Reset
REQ-026 SHALL on clr at a clock edge clear all of score_flat, id_flat, entry_valid, done, placed and rank to 0, and go to IDLE (in_ready=1 in the next cycle).
REQ-027 SHALL give clr priority over any operation: clr in CMP or INS aborts it with no table write and no done pulse.

Configuration
REQ-028 SHALL support macro LEADERBOARD_DEDUP_EN; without it, the same id may occupy several entries per REQ-019..022.
REQ-029 SHALL, with LEADERBOARD_DEDUP_EN, in CMP also find entry e whose id == in_id.
- If e exists and score[e] > in_score: discard, placed=0, table unchanged.
- If e exists and score[e] <= in_score: p <= e always; remove e, shift entries p..e-1 down by one, write new at p; no entry drops off; rank=p.
- If no e exists: behaviour is REQ-019..022.

Verification
REQ-030 SHALL cover: DEPTH=3, clr then submit 50/id1 -> two edges after accept: entry0=50/1, entry_valid=001, done=1, placed=1, rank=0.
REQ-031 SHALL cover: then 70/2, 60/3, 55/4 -> 70/2,60/3,55/4; then submit 40/6 -> placed=0, table unchanged.
REQ-032 SHALL cover: with table 70/2,60/3,55/4, submit 60/5 -> 70/2,60/5,60/3, rank=1.
REQ-033 SHALL cover: clr asserted during INS -> all outputs 0, no done, in_ready=1 next cycle.
REQ-034 SHALL cover: in_valid held with new data while busy -> second item accepted only on the cycle after done, exactly once.
REQ-035 SHALL cover: with DEDUP, table 70/2,60/5,60/3, submit 80/3 -> 80/3,70/2,60/5, rank=0; then 65/2 -> placed=0; without DEDUP, 65/2 -> 80/3,70/2,65/2.

Source files
------------

// File: rtl/leaderboard_sorted.sv
// Sorted top-DEPTH score table, entry 0 highest; IDLE->CMP->INS, done one cycle after INS.
// Define LEADERBOARD_DEDUP_EN to keep at most one entry per user id (best score wins).
module leaderboard_sorted #(
  parameter int DEPTH   = 3,
  parameter int SCORE_W = 8,
  parameter int ID_W    = 3,
  localparam int RW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SCORE_W-1:0]       in_score,
  input  logic [ID_W-1:0]          in_id,
  output logic [DEPTH*SCORE_W-1:0] score_flat,
  output logic [DEPTH*ID_W-1:0]    id_flat,
  output logic [DEPTH-1:0]         entry_valid,
  output logic                     done,
  output logic                     placed,
  output logic [RW-1:0]            rank
);

  typedef enum logic [1:0] {IDLE, CMP, INS} state_t;

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   score_q [DEPTH];
  logic [SCORE_W-1:0]   score_d [DEPTH];
  logic [ID_W-1:0]      id_q    [DEPTH];
  logic [ID_W-1:0]      id_d    [DEPTH];
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [SCORE_W-1:0]   sub_score_q;
  logic [ID_W-1:0]      sub_id_q;
  logic [RW-1:0]        p_q, pos;
  logic                 p_found_q, pos_found;
  logic                 done_q, placed_q;
  logic [RW-1:0]        rank_q;
  int                   last;
`ifdef LEADERBOARD_DEDUP_EN
  logic [RW-1:0]        e_q, dup;
  logic                 e_found_q, dup_found, discard;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CMP;
      CMP:     state_d = INS;
      INS:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Descending scans so the lowest matching index is the one that sticks.
  always_comb begin
    pos       = '0;
    pos_found = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (!vld_q[k] || sub_score_q >= score_q[k]) begin
        pos       = RW'(k);
        pos_found = 1'b1;
      end
    end
`ifdef LEADERBOARD_DEDUP_EN
    dup       = '0;
    dup_found = 1'b0;
    discard   = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (vld_q[k] && id_q[k] == sub_id_q) begin
        dup       = RW'(k);
        dup_found = 1'b1;
        discard   = (score_q[k] > sub_score_q);
      end
    end
    if (discard) pos_found = 1'b0;
`endif
  end

  // Entries in (p, last] take their upper neighbour; a removed duplicate bounds the shift.
  always_comb begin
`ifdef LEADERBOARD_DEDUP_EN
    last = e_found_q ? int'(e_q) : DEPTH - 1;
`else
    last = DEPTH - 1;
`endif
    vld_d = vld_q;
    for (int k = 0; k < DEPTH; k++) begin
      score_d[k] = score_q[k];
      id_d[k]    = id_q[k];
    end
    if (state_q == INS && p_found_q) begin
      for (int k = 1; k < DEPTH; k++) begin
        if (k > int'(p_q) && k <= last) begin
          score_d[k] = score_q[k-1];
          id_d[k]    = id_q[k-1];
          vld_d[k]   = vld_q[k-1];
        end
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (k == int'(p_q)) begin
          score_d[k] = sub_score_q;
          id_d[k]    = sub_id_q;
          vld_d[k]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      vld_q       <= '0;
      sub_score_q <= '0;
      sub_id_q    <= '0;
      p_q         <= '0;
      p_found_q   <= 1'b0;
      done_q      <= 1'b0;
      placed_q    <= 1'b0;
      rank_q      <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        score_q[k] <= '0;
        id_q[k]    <= '0;
      end
`ifdef LEADERBOARD_DEDUP_EN
      e_q       <= '0;
      e_found_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      for (int k = 0; k < DEPTH; k++) begin
        score_q[k] <= score_d[k];
        id_q[k]    <= id_d[k];
      end
      done_q <= (state_q == INS);
      if (state_q == IDLE && in_valid) begin
        sub_score_q <= in_score;
        sub_id_q    <= in_id;
      end
      if (state_q == CMP) begin
        p_q       <= pos;
        p_found_q <= pos_found;
`ifdef LEADERBOARD_DEDUP_EN
        e_q       <= dup;
        e_found_q <= dup_found;
`endif
      end
      if (state_q == INS) begin
        placed_q <= p_found_q;
        rank_q   <= p_found_q ? p_q : '0;
      end
    end
  end

  always_comb begin
    score_flat = '0;
    id_flat    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      score_flat[k*SCORE_W +: SCORE_W] = score_q[k];
      id_flat[k*ID_W +: ID_W]          = id_q[k];
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign entry_valid = vld_q;
  assign done        = done_q;
  assign placed      = placed_q;
  assign rank        = rank_q;

endmodule

// File: tb/tb_leaderboard_sorted.sv
// Scoreboard bench for leaderboard_sorted (DEPTH=3): driver queues expected results, monitor checks on done.
module tb_leaderboard_sorted;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_score;
  logic [2:0]  in_id;
  logic [23:0] score_flat;
  logic [8:0]  id_flat;
  logic [2:0]  entry_valid;
  logic        done;
  logic        placed;
  logic [1:0]  rank;

  leaderboard_sorted #(.DEPTH(3), .SCORE_W(8), .ID_W(3)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_score(in_score), .in_id(in_id), .score_flat(score_flat),
    .id_flat(id_flat), .entry_valid(entry_valid), .done(done),
    .placed(placed), .rank(rank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pl;
    logic [1:0]  rk;
    logic [23:0] sf;
    logic [8:0]  idf;
    logic [2:0]  v;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input bit pl, input int rk, input int s0, input int i0,
                              input int s1, input int i1, input int s2, input int i2,
                              input int v);
    exp_t e;
    e.pl  = pl;
    e.rk  = 2'(rk);
    e.sf  = {8'(s2), 8'(s1), 8'(s0)};
    e.idf = {3'(i2), 3'(i1), 3'(i0)};
    e.v   = 3'(v);
    e.due = 0;
    return e;
  endfunction

  // Monitor: every done must match the oldest queued expectation, on its due cycle.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.due);
        chk("placed", 32'(placed), 32'(e.pl));
        if (e.pl) chk("rank", 32'(rank), 32'(e.rk));
        chk("score_flat", 32'(score_flat), 32'(e.sf));
        chk("id_flat", 32'(id_flat), 32'(e.idf));
        chk("entry_valid", 32'(entry_valid), 32'(e.v));
        chk("ready_with_done", 32'(in_ready), 32'd1);
      end
    end
  end

  task automatic submit(input int s, input int id, input exp_t e, input bit hold);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_score = 8'(s);
    in_id    = 3'(id);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      e.due = cyc + 3;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr      = 1'b1;
    in_valid = 1'b0;
    in_score = '0;
    in_id    = '0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_score", 32'(score_flat), 32'd0);
    chk("rst_id", 32'(id_flat), 32'd0);
    chk("rst_valid", 32'(entry_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_placed", 32'(placed), 32'd0);
    chk("rst_rank", 32'(rank), 32'd0);

    submit(50, 1, mk(1, 0, 50, 1, 0, 0, 0, 0, 3'b001), 0);
    submit(70, 2, mk(1, 0, 70, 2, 50, 1, 0, 0, 3'b011), 0);
    submit(60, 3, mk(1, 1, 70, 2, 60, 3, 50, 1, 3'b111), 0);
    submit(55, 4, mk(1, 2, 70, 2, 60, 3, 55, 4, 3'b111), 0);
    submit(40, 6, mk(0, 0, 70, 2, 60, 3, 55, 4, 3'b111), 0);
    submit(60, 5, mk(1, 1, 70, 2, 60, 5, 60, 3, 3'b111), 0);
    submit(80, 3, mk(1, 0, 80, 3, 70, 2, 60, 5, 3'b111), 0);
`ifdef LEADERBOARD_DEDUP_EN
    submit(65, 2, mk(0, 0, 80, 3, 70, 2, 60, 5, 3'b111), 0);
    submit(90, 5, mk(1, 0, 90, 5, 80, 3, 70, 2, 3'b111), 0);
    submit(80, 3, mk(1, 1, 90, 5, 80, 3, 70, 2, 3'b111), 0);
`else
    submit(65, 2, mk(1, 2, 80, 3, 70, 2, 65, 2, 3'b111), 0);
    submit(90, 5, mk(1, 0, 90, 5, 80, 3, 70, 2, 3'b111), 0);
    submit(80, 3, mk(1, 1, 90, 5, 80, 3, 80, 3, 3'b111), 0);
`endif
    repeat (4) @(posedge clk);

    // Abort a submission with clr during INS: no done, no table write, everything zeroed.
    @(negedge clk);
    in_valid = 1'b1;
    in_score = 8'd99;
    in_id    = 3'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_in_ready", 32'(in_ready), 32'd1);
    chk("clr_score", 32'(score_flat), 32'd0);
    chk("clr_id", 32'(id_flat), 32'd0);
    chk("clr_valid", 32'(entry_valid), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_placed", 32'(placed), 32'd0);
    repeat (4) @(posedge clk);

    // in_valid stays high with new data while busy; second item must be taken exactly once.
    submit(10, 7, mk(1, 0, 10, 7, 0, 0, 0, 0, 3'b001), 1);
    in_score = 8'd20;
    in_id    = 3'd6;
    submit(20, 6, mk(1, 0, 20, 6, 10, 7, 0, 0, 3'b011), 0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("final_table", 32'(score_flat), 32'h000A14);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
